branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter PC_W, default 9, program-counter width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16, predictor table depth; a power of two, at least 2.
REQ-003 SHALL derive IDX_W = log2(ENTRIES) and TAG_W = PC_W-2-IDX_W; TAG_W SHALL be at least 1.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high. Ports: clk  in  1  sole clock, rising edge. reset  in  1  synchronous active-high reset.
REQ-005 fetch_PC  in  PC_W  PC being fetched in IF.
REQ-006 pred_taken  out  1  IF prediction: redirect fetch.
REQ-007 pred_target  out  32  IF predicted next PC.
REQ-008 upd_valid  in  1  EX resolution strobe.
REQ-009 upd_PC  in  PC_W  PC of the resolved instruction.
REQ-010 upd_ctrl  in  2  transfer type: 00 none, 01 branch, 10 JAL, 11 JALR.
REQ-011 upd_taken  in  1  resolved branch outcome; ignored for JAL/JALR.
REQ-012 upd_target  in  32  resolved target.
REQ-013 upd_pred_taken  in  1  prediction that was made in IF for this instruction, carried down the pipe.
REQ-014 upd_pred_target  in  32  target that was predicted in IF, carried down the pipe.
REQ-015 mispredict  out  1  flush request.
REQ-016 redirect_PC  out  32  correct next PC when mispredict=1.

Function
REQ-017 Index SHALL be PC[IDX_W+1:2] and tag SHALL be PC[PC_W-1:IDX_W+2]; each entry SHALL hold valid, tag, 32-bit target, 2-bit counter and an is_jump flag.
REQ-018 Lookup SHALL be combinational with zero latency: hit = valid and tag match.
REQ-019 pred_taken SHALL equal hit and (is_jump or counter[1]).
REQ-020 pred_target SHALL equal the stored target when pred_taken=1, else zero-extended fetch_PC+4, using 32-bit arithmetic.
REQ-021 An update SHALL occur on a rising edge when upd_valid=1 and upd_ctrl is not 00; no table write SHALL occur otherwise.
REQ-022 Update, hit, branch: the counter SHALL saturate upward to 11 if taken and downward to 00 if not taken; the target SHALL be written only if taken.
REQ-023 Update, miss, taken branch: the entry SHALL be allocated (overwriting any occupant) with valid=1, new tag, upd_target, counter 10 and is_jump=0.
REQ-024 Update, miss, not-taken branch: no allocation SHALL occur.
REQ-025 JAL/JALR update: the entry SHALL be written with valid=1, tag, upd_target, counter 11 and is_jump=1, treating the instruction as taken.
REQ-026 A lookup and an update to the same index in one cycle SHALL see the pre-update contents; there SHALL be no bypass.
REQ-027 mispredict SHALL be registered, asserted for exactly the cycle after a qualifying update, when the effective taken value differs from upd_pred_taken, or when both are 1 and upd_target differs from upd_pred_target.
REQ-028 redirect_PC SHALL be registered in the same cycle: upd_target if the effective taken value is 1, else zero-extended upd_PC+4.
REQ-029 redirect_PC SHALL hold its last value while mispredict=0.

Reset
REQ-030 Reset SHALL clear all valid bits, set all counters to 01, and drive mispredict=0 and redirect_PC=0 on the next edge.
REQ-031 While reset is asserted, reset SHALL win over any simultaneous update, and the lookup SHALL report a miss from the first post-reset cycle.

Configuration
REQ-032 With BRANCH_PREDICTOR_STATS_EN defined, the block SHALL add outputs stat_updates[31:0] and stat_mispredicts[31:0], counting qualifying updates and mispredicts, saturating at 0xFFFFFFFF and cleared by reset.
REQ-033 Without BRANCH_PREDICTOR_STATS_EN, these ports and counters SHALL be absent.

Structure
REQ-034 Package bp_pkg SHALL hold the ctrl_transfer enum (NONE, BRANCH, JAL, JALR) and the counter enum (SNT=00, WNT=01, WT=10, ST=11).
REQ-035 Sub-module bp_sat_counter SHALL implement the 2-bit counter next-state logic, instantiated per entry or shared on the update path.

Verification
REQ-036 Reset, then fetch_PC=0x040 -> pred_taken=0, pred_target=0x044.
REQ-037 Branch at 0x040 taken to 0x080 (predicted not taken) -> mispredict=1 next cycle, redirect_PC=0x080; next lookup of 0x040 -> pred_taken=1, pred_target=0x080.
REQ-038 Same branch resolved not-taken twice -> counter 10->01->00, lookup pred_taken=0, first resolution raises mispredict with redirect_PC=0x044.
REQ-039 JALR at 0x010 to 0x100, then to 0x120 with upd_pred_target=0x100 -> second resolution raises mispredict with redirect 0x120, and the stored target updates to 0x120.
REQ-040 Update and lookup of the same index in the same cycle -> lookup shows old entry; aliasing PC 0x050 vs 0x010 (ENTRIES=16) -> tag mismatch, miss.
REQ-041 Reset asserted together with upd_valid -> no allocation; with the macro defined, the stats counters read 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor slice.
//   ctrl_transfer_e : transfer type carried on upd_ctrl (NONE/BRANCH/JAL/JALR)
//   cnt_e           : 2-bit saturating direction counter encodings
package bp_pkg;

  typedef enum logic [1:0] {
    NONE   = 2'b00,
    BRANCH = 2'b01,
    JAL    = 2'b10,
    JALR   = 2'b11
  } ctrl_transfer_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_e;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and EX-resolution bus of the branch predictor.
//   master : pipeline side (drives fetch_PC and upd_*, receives prediction/flush)
//   slave  : predictor side
// Signals: fetch_PC, pred_taken, pred_target, upd_valid, upd_PC, upd_ctrl,
//          upd_taken, upd_target, upd_pred_taken, upd_pred_target,
//          mispredict, redirect_PC.
interface branch_predictor_if #(
  parameter int unsigned PC_W = 9
);
  logic [PC_W-1:0] fetch_PC;
  logic            pred_taken;
  logic [31:0]     pred_target;
  logic            upd_valid;
  logic [PC_W-1:0] upd_PC;
  logic [1:0]      upd_ctrl;
  logic            upd_taken;
  logic [31:0]     upd_target;
  logic            upd_pred_taken;
  logic [31:0]     upd_pred_target;
  logic            mispredict;
  logic [31:0]     redirect_PC;

  modport master (
    output fetch_PC, upd_valid, upd_PC, upd_ctrl, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_PC
  );

  modport slave (
    input  fetch_PC, upd_valid, upd_PC, upd_ctrl, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, mispredict, redirect_PC
  );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Next-state logic of a 2-bit saturating direction counter.
//   cnt_i   : current counter value
//   taken_i : resolved outcome (1 = count up, 0 = count down)
//   cnt_o   : next counter value, saturating at SNT and ST
module bp_sat_counter
  import bp_pkg::*;
(
  input  cnt_e cnt_i,
  input  logic taken_i,
  output cnt_e cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    unique case (cnt_i)
      SNT: cnt_o = taken_i ? WNT : SNT;
      WNT: cnt_o = taken_i ? WT  : SNT;
      WT:  cnt_o = taken_i ? ST  : WNT;
      ST:  cnt_o = taken_i ? ST  : WT;
      default: cnt_o = cnt_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Lookup is combinational on fetch_PC; updates are written on the rising
// edge from the EX resolution bus, and a registered flush (mispredict +
// redirect_PC) is raised the cycle after a wrong prediction is resolved.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : branch_predictor_if.slave (lookup + resolution signals)
//   stat_updates, stat_mispredicts : saturating event counters, present only
//                when BRANCH_PREDICTOR_STATS_EN is defined
// Parameters: PC_W (>= IDX_W+3), ENTRIES (power of two, >= 2).
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned PC_W    = 9,
  parameter int unsigned ENTRIES = 16
) (
  input  logic                clk,
  input  logic                reset,
  branch_predictor_if.slave   bus
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [31:0]         stat_updates,
  output logic [31:0]         stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - 2 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];
  cnt_e             cnt_q    [ENTRIES];
  cnt_e             cnt_d    [ENTRIES];
  logic             jmp_q    [ENTRIES];
  logic             jmp_d    [ENTRIES];

  logic             mispredict_q, mispredict_d;
  logic [31:0]      redirect_q, redirect_d;

  // Lookup path
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  always_comb begin
    f_idx           = bus.fetch_PC[IDX_W+1:2];
    f_tag           = bus.fetch_PC[PC_W-1:IDX_W+2];
    f_hit           = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    bus.pred_taken  = f_hit && (jmp_q[f_idx] || cnt_q[f_idx][1]);
    bus.pred_target = bus.pred_taken ? target_q[f_idx]
                                     : 32'(bus.fetch_PC) + 32'd4;
  end

  // Update path
  ctrl_transfer_e   ctrl;
  logic             qual;
  logic             is_branch;
  logic             eff_taken;
  logic             mis;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  cnt_e             u_cnt_nxt;

  bp_sat_counter u_cnt (
    .cnt_i   (cnt_q[u_idx]),
    .taken_i (bus.upd_taken),
    .cnt_o   (u_cnt_nxt)
  );

  always_comb begin
    ctrl      = ctrl_transfer_e'(bus.upd_ctrl);
    qual      = bus.upd_valid && (ctrl != NONE);
    is_branch = (ctrl == BRANCH);
    // JAL/JALR are always taken regardless of upd_taken
    eff_taken = is_branch ? bus.upd_taken : 1'b1;
    u_idx     = bus.upd_PC[IDX_W+1:2];
    u_tag     = bus.upd_PC[PC_W-1:IDX_W+2];
    u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    jmp_d    = jmp_q;

    if (qual) begin
      if (is_branch) begin
        if (u_hit) begin
          cnt_d[u_idx] = u_cnt_nxt;
          if (bus.upd_taken) target_d[u_idx] = bus.upd_target;
        end else if (bus.upd_taken) begin
          valid_d[u_idx]  = 1'b1;
          tag_d[u_idx]    = u_tag;
          target_d[u_idx] = bus.upd_target;
          cnt_d[u_idx]    = WT;
          jmp_d[u_idx]    = 1'b0;
        end
      end else begin
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = bus.upd_target;
        cnt_d[u_idx]    = ST;
        jmp_d[u_idx]    = 1'b1;
      end
    end

    mis = qual && ((eff_taken != bus.upd_pred_taken) ||
                   (eff_taken && bus.upd_pred_taken &&
                    (bus.upd_target != bus.upd_pred_target)));
    mispredict_d = mis;
    redirect_d   = redirect_q;
    if (mis) redirect_d = eff_taken ? bus.upd_target
                                    : 32'(bus.upd_PC) + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= WNT;
        jmp_q[i]    <= 1'b0;
      end
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      jmp_q        <= jmp_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
    end
  end

  assign bus.mispredict  = mispredict_q;
  assign bus.redirect_PC = redirect_q;

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] stat_upd_q, stat_upd_d;
  logic [31:0] stat_mis_q, stat_mis_d;

  always_comb begin
    stat_upd_d = stat_upd_q;
    stat_mis_d = stat_mis_q;
    if (qual && (stat_upd_q != '1)) stat_upd_d = stat_upd_q + 32'd1;
    if (mis  && (stat_mis_q != '1)) stat_mis_d = stat_mis_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_upd_q <= stat_upd_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_updates     = stat_upd_q;
  assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (PC_W=9, ENTRIES=16).
// Expected values are queued when stimulus is applied and compared once the
// corresponding DUT output is valid.
module tb_branch_predictor;
  import bp_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predictor_if #(.PC_W(9)) bus ();

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;
`endif

  branch_predictor #(.PC_W(9), .ENTRIES(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus.slave)
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  typedef enum int { K_PT, K_PTGT, K_MP, K_RD, K_SU, K_SM } kind_e;
  typedef struct {
    kind_e       kind;
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input kind_e kind, input string tag,
                            input logic [31:0] val);
    exp_t e;
    e.kind = kind;
    e.tag  = tag;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = 'x;
      case (e.kind)
        K_PT:   obs = {31'd0, bus.pred_taken};
        K_PTGT: obs = bus.pred_target;
        K_MP:   obs = {31'd0, bus.mispredict};
        K_RD:   obs = bus.redirect_PC;
`ifdef BRANCH_PREDICTOR_STATS_EN
        K_SU:   obs = stat_updates;
        K_SM:   obs = stat_mispredicts;
`endif
        default: obs = 'x;
      endcase
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic idle_upd();
    bus.upd_valid       = 1'b0;
    bus.upd_PC          = '0;
    bus.upd_ctrl        = NONE;
    bus.upd_taken       = 1'b0;
    bus.upd_target      = '0;
    bus.upd_pred_taken  = 1'b0;
    bus.upd_pred_target = '0;
  endtask

  task automatic drive_upd(input logic vld, input ctrl_transfer_e ctrl,
                           input logic [8:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic ptaken,
                           input logic [31:0] ptgt);
    bus.upd_valid       = vld;
    bus.upd_PC          = pc;
    bus.upd_ctrl        = ctrl;
    bus.upd_taken       = taken;
    bus.upd_target      = tgt;
    bus.upd_pred_taken  = ptaken;
    bus.upd_pred_target = ptgt;
  endtask

  // Comb lookup check at the current fetch_PC
  task automatic lookup(input string tag, input logic [8:0] pc,
                        input logic tk, input logic [31:0] tgt);
    bus.fetch_PC = pc;
    #1;
    expect_val(K_PT,   {tag, "_taken"},  {31'd0, tk});
    expect_val(K_PTGT, {tag, "_target"}, tgt);
    drain();
  endtask

  // Apply the driven update on the next edge, then check the registered flush
  task automatic resolve(input string tag, input logic mp,
                         input logic [31:0] rd);
    expect_val(K_MP, {tag, "_mispredict"}, {31'd0, mp});
    expect_val(K_RD, {tag, "_redirect"},   rd);
    @(posedge clk);
    #1;
    drain();
    @(negedge clk);
    idle_upd();
  endtask

  initial begin
    idle_upd();
    bus.fetch_PC = '0;
    reset = 1'b1;
    // Update held during reset must not allocate
    drive_upd(1'b1, BRANCH, 9'h040, 1'b1, 32'h080, 1'b0, 32'h044);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_upd();
    expect_val(K_MP, "rst_mispredict", 32'd0);
    expect_val(K_RD, "rst_redirect",   32'd0);
`ifdef BRANCH_PREDICTOR_STATS_EN
    expect_val(K_SU, "rst_stat_upd", 32'd0);
    expect_val(K_SM, "rst_stat_mis", 32'd0);
`endif
    drain();
    lookup("rst_lookup_040", 9'h040, 1'b0, 32'h044);

    // Taken branch allocated; same-cycle lookup sees old (empty) entry
    drive_upd(1'b1, BRANCH, 9'h040, 1'b1, 32'h080, 1'b0, 32'h044);
    lookup("same_cycle_040", 9'h040, 1'b0, 32'h044);
    resolve("br_taken", 1'b1, 32'h080);
    lookup("alloc_040", 9'h040, 1'b1, 32'h080);
    // No update: flush drops, redirect holds
    resolve("idle1", 1'b0, 32'h080);

    // Not taken twice: WT -> WNT -> SNT
    drive_upd(1'b1, BRANCH, 9'h040, 1'b0, 32'h080, 1'b1, 32'h080);
    resolve("br_nt1", 1'b1, 32'h044);
    lookup("after_nt1", 9'h040, 1'b0, 32'h044);
    drive_upd(1'b1, BRANCH, 9'h040, 1'b0, 32'h080, 1'b0, 32'h044);
    resolve("br_nt2", 1'b0, 32'h044);
    lookup("after_nt2", 9'h040, 1'b0, 32'h044);
    // One taken from SNT gives WNT: still predicts not taken
    drive_upd(1'b1, BRANCH, 9'h040, 1'b1, 32'h080, 1'b0, 32'h044);
    resolve("br_t_from_snt", 1'b1, 32'h080);
    lookup("snt_plus1", 9'h040, 1'b0, 32'h044);

    // JALR install, then target change; upd_taken ignored for jumps
    drive_upd(1'b1, JALR, 9'h010, 1'b0, 32'h100, 1'b0, 32'h014);
    resolve("jalr1", 1'b1, 32'h100);
    lookup("jalr_010", 9'h010, 1'b1, 32'h100);
    lookup("alias_050", 9'h050, 1'b0, 32'h054);
    drive_upd(1'b1, JALR, 9'h010, 1'b0, 32'h120, 1'b1, 32'h100);
    resolve("jalr2", 1'b1, 32'h120);
    lookup("jalr_010_new", 9'h010, 1'b1, 32'h120);
    drive_upd(1'b1, JALR, 9'h010, 1'b0, 32'h120, 1'b1, 32'h120);
    resolve("jalr3_ok", 1'b0, 32'h120);

    // Not-taken branch miss: no allocation, no flush
    drive_upd(1'b1, BRANCH, 9'h0C0, 1'b0, 32'h1F0, 1'b0, 32'h0C4);
    resolve("br_nt_miss", 1'b0, 32'h120);
    lookup("no_alloc_0c0", 9'h0C0, 1'b0, 32'h0C4);

    // ctrl NONE with valid, and JAL without valid: neither qualifies
    drive_upd(1'b1, NONE, 9'h080, 1'b1, 32'h1A0, 1'b1, 32'h084);
    resolve("ctrl_none", 1'b0, 32'h120);
    lookup("none_080", 9'h080, 1'b0, 32'h084);
    drive_upd(1'b0, JAL, 9'h084, 1'b1, 32'h1B0, 1'b0, 32'h088);
    resolve("jal_novalid", 1'b0, 32'h120);
    lookup("novalid_084", 9'h084, 1'b0, 32'h088);

    // JAL installs as always-taken
    drive_upd(1'b1, JAL, 9'h084, 1'b0, 32'h1B0, 1'b0, 32'h088);
    resolve("jal", 1'b1, 32'h1B0);
    lookup("jal_084", 9'h084, 1'b1, 32'h1B0);

`ifdef BRANCH_PREDICTOR_STATS_EN
    // Qualifying: br_taken, nt1, nt2, t_from_snt, jalr1-3, nt_miss, jal = 9
    // Mispredicts: br_taken, nt1, t_from_snt, jalr1, jalr2, jal = 6
    expect_val(K_SU, "stat_upd", 32'd9);
    expect_val(K_SM, "stat_mis", 32'd6);
    drain();
`endif

    // Reset wins over a simultaneous update
    @(negedge clk);
    reset = 1'b1;
    drive_upd(1'b1, JAL, 9'h040, 1'b0, 32'h150, 1'b0, 32'h044);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_upd();
    expect_val(K_MP, "rst2_mispredict", 32'd0);
    expect_val(K_RD, "rst2_redirect",   32'd0);
`ifdef BRANCH_PREDICTOR_STATS_EN
    expect_val(K_SU, "rst2_stat_upd", 32'd0);
    expect_val(K_SM, "rst2_stat_mis", 32'd0);
`endif
    drain();
    lookup("rst2_040", 9'h040, 1'b0, 32'h044);
    lookup("rst2_010", 9'h010, 1'b0, 32'h014);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
